// File: rtl/taglist_reader_if.sv
// Bus bundle between the taglist reader, its controller, the taglist RAM read port and the ROM path.
// The master side drives requests and RAM read data; the slave side is the reader itself.
interface taglist_reader_if #(
  parameter int SEQ_W  = 7,
  parameter int ADDR_W = 10
);
  logic              start;
  logic [SEQ_W-1:0]  seq_req;
  logic              hold;
  logic              stop;
  logic [SEQ_W-1:0]  ram_addr;
  logic [31:0]       ram_data;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_valid;
  logic              busy;
  logic              done;
  logic              err;
  logic              end_rom;

  modport master (
    output start, seq_req, hold, stop, ram_data,
    input  ram_addr, rom_addr, rom_valid, busy, done, err, end_rom
  );

  modport slave (
    input  start, seq_req, hold, stop, ram_data,
    output ram_addr, rom_addr, rom_valid, busy, done, err, end_rom
  );
endinterface

// File: rtl/taglist_reader.sv
// Fetches one taglist entry from the synchronous taglist RAM, validates it and streams first..last.
// Define TAGLIST_READER_LOOP_EN to replay first..last continuously until stop instead of finishing.
module taglist_reader #(
  parameter int SEQ_W  = 7,
  parameter int ADDR_W = 10
) (
  input logic             clk_1KHz,
  input logic             reset,
  taglist_reader_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_PLAY,
    ST_FINISH
  } state_e;

  typedef struct packed {
    logic [3:0]  rsvd;
    logic [6:0]  seq;
    logic [9:0]  first;
    logic [9:0]  last;
    logic        end_rom;
  } entry_t;

  state_e            state_q,    state_d;
  logic [SEQ_W-1:0]  ram_addr_q, ram_addr_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] first_q,    first_d;
  logic [ADDR_W-1:0] last_q,     last_d;
  logic              end_rom_q,  end_rom_d;
  logic              valid_q,    valid_d;
  logic              err_flag_q, err_flag_d;

  entry_t            entry;
  logic [ADDR_W-1:0] entry_first;
  logic [ADDR_W-1:0] entry_last;
  logic              entry_ok;

  assign entry       = entry_t'(bus.ram_data);
  assign entry_first = ADDR_W'(entry.first);
  assign entry_last  = ADDR_W'(entry.last);
  assign entry_ok    = (entry.rsvd == 4'd0) &&
                       (SEQ_W'(entry.seq) == ram_addr_q) &&
                       (entry_first <= entry_last);

  // hold is sampled at a clock edge and gates the following cycle's emission, keeping
  // rom_valid a pure register output.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    ram_addr_d = ram_addr_q;
    rom_addr_d = rom_addr_q;
    first_d    = first_q;
    last_d     = last_q;
    end_rom_d  = end_rom_q;
    valid_d    = 1'b0;
    err_flag_d = err_flag_q;

    unique case (state_q)
      ST_IDLE: begin
        err_flag_d = 1'b0;
        if (bus.start && !bus.stop) begin
          ram_addr_d = bus.seq_req;
          state_d    = ST_FETCH;
        end
      end

      ST_FETCH: begin
        state_d = bus.stop ? ST_IDLE : ST_CHECK;
      end

      ST_CHECK: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (entry_ok) begin
          first_d    = entry_first;
          last_d     = entry_last;
          rom_addr_d = entry_first;
          end_rom_d  = entry.end_rom;
          valid_d    = !bus.hold;
          state_d    = ST_PLAY;
        end else begin
          err_flag_d = 1'b1;
          state_d    = ST_FINISH;
        end
      end

      ST_PLAY: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (valid_q && (rom_addr_q == last_q)) begin
          // The last address is compared before any increment, so last==max never wraps.
`ifdef TAGLIST_READER_LOOP_EN
          rom_addr_d = first_q;
          valid_d    = !bus.hold;
`else
          state_d    = ST_FINISH;
`endif
        end else begin
          if (valid_q) begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
          end
          valid_d = !bus.hold;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_1KHz or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q    <= ST_IDLE;
      ram_addr_q <= '0;
      rom_addr_q <= '0;
      first_q    <= '0;
      last_q     <= '0;
      end_rom_q  <= 1'b0;
      valid_q    <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      rom_addr_q <= rom_addr_d;
      first_q    <= first_d;
      last_q     <= last_d;
      end_rom_q  <= end_rom_d;
      valid_q    <= valid_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_valid = valid_q;
  assign bus.end_rom   = end_rom_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_FINISH) && !err_flag_q;
  assign bus.err       = (state_q == ST_FINISH) &&  err_flag_q;

endmodule
